pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register, the general successor to the fixed MEM/WB latch. It carries a control vector, NUM_DATA data words and a destination register index between any two pipeline stages. It adds a valid/ready handshake, stall back-pressure, synchronous flush and an optional skid entry, so a stall never creates a combinational ready path through the stage. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-boundary parameters.

## Interface
Parameters:
- DATA_W, 32, width of one data word
- NUM_DATA, 2, number of data words carried (MEM/WB: read data + ALU address)
- RD_W, 5, destination register index width
- CTRL_W, 2, control vector width (MEM/WB: {regwrite, memtoreg})

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; priority over every other input
- in_valid  in  1  upstream presents a transfer
- in_ready  out  1  stage accepts the transfer this cycle
- in_ctrl  in  CTRL_W  upstream control vector
- in_data  in  NUM_DATA*DATA_W  upstream data words, word k at bits [k*DATA_W +: DATA_W]
- in_rd  in  RD_W  upstream destination index
- flush  in  1  synchronous kill of all held and incoming entries
- out_valid  out  1  stage holds a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  held control; forced 0 whenever out_valid=0
- out_data  out  NUM_DATA*DATA_W  held data words
- out_rd  out  RD_W  held destination index

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Storage: main entry (drives outputs); skid entry when PIPE_STAGE_SKID_EN is defined.
- States (skid build): EMPTY (no valid entries), ONE (main valid), TWO (main and skid valid).
  - EMPTY: in transfer -> ONE.
  - ONE: in only -> TWO (load skid); out only -> EMPTY; both -> ONE (main reloaded from input).
  - TWO: in_ready=0; out transfer -> ONE (skid moves to main, skid cleared).
- in_ready = !skid_valid, a registered value with no combinational dependence on out_ready.
- Order is strictly FIFO; no entry is dropped or duplicated.
- flush=1: next state EMPTY; any input transferred that cycle is discarded; out_ctrl and out_valid go to 0. out_data/out_rd hold their values (don't-care while invalid).
- Bubble rule: whenever main becomes invalid (drain, flush, reset), the out_ctrl register clears to 0, so no write-enable leaks from a bubble.
- Reset: out_valid=0, out_ctrl=0, out_data=0, out_rd=0, skid cleared, in_ready=1 on the following cycle.

## Timing
- Latency: 1 cycle from an in transfer to out_valid=1 (empty stage).
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Stall: out_ready low for N cycles with continuous input -> exactly one extra entry is absorbed, then in_ready=0 from the next cycle.
- flush and reset are sampled at the rising edge only; reset mid-stall empties both entries.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid entry present, three-state behaviour as above.
- Not defined: main entry only; in_ready = out_ready || !out_valid (combinational). States are EMPTY/ONE. Latency, flush and reset behaviour are unchanged.

## Structure
- Shared package pipe_pkg: default width constants (DATA_W_DEF, RD_W_DEF), state encoding typedef pipe_state_t {EMPTY, ONE, TWO}, MEM/WB control field index constants (CTRL_REGWRITE=1, CTRL_MEMTOREG=0).
- One natural sub-module: pipe_entry_reg, one storage entry (valid, ctrl, data, rd) with load/clear. It is instantiated for main and, under the macro, for skid.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, out_rd=0; first transfer after release appears 1 cycle later.
- Streaming: 8 back-to-back entries (data k, rd=k) with out_ready=1 -> out_valid on 8 consecutive cycles, same order, no gaps.
- Stall: out_ready=0 for 5 cycles during streaming -> (skid build) in_ready drops after 2 accepted entries; release -> both drain in order and none is lost.
- Flush: flush while TWO holding ctrl=2'b11 -> next cycle out_valid=0, out_ctrl=2'b00, in_ready=1; entry presented during flush never appears.
- Simultaneous: in and out transfers in ONE every cycle -> state stays ONE, out matches input delayed exactly 1 cycle.
- No-macro build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipeline stage register slice.
//   - default width constants for stage payloads
//   - pipe_state_t occupancy encoding (EMPTY / ONE / TWO)
//   - MEM/WB control vector field indices
package pipe_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_DATA_DEF = 2;
  localparam int unsigned RD_W_DEF     = 5;
  localparam int unsigned CTRL_W_DEF   = 2;

  // MEM/WB control vector layout: {regwrite, memtoreg}
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 0;

  // Number of valid entries held by the stage
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one storage entry (valid, ctrl, data, rd) of a pipeline stage.
// Ports:
//   clk, reset       clock; synchronous active-high reset clears everything
//   load             capture d_ctrl/d_data/d_rd and set valid
//   clear            drop the entry: valid and ctrl go to 0, data/rd hold
//   d_ctrl/d_data/d_rd  entry payload to load
//   q_valid/q_ctrl/q_data/q_rd  registered entry contents
// clear wins over load so a kill can never be overridden by a same-cycle load.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_DATA = NUM_DATA_DEF,
  parameter int unsigned RD_W     = RD_W_DEF,
  parameter int unsigned CTRL_W   = CTRL_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       clear,
  input  logic [CTRL_W-1:0]          d_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] d_data,
  input  logic [RD_W-1:0]            d_rd,
  output logic                       q_valid,
  output logic [CTRL_W-1:0]          q_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] q_data,
  output logic [RD_W-1:0]            q_rd
);

  // Entry storage; ctrl is zeroed with valid so a bubble never carries enables
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
      q_rd    <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
      q_rd    <= d_rd;
    end
  end

endmodule : pipe_entry_reg

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with valid/ready handshake,
// stall back-pressure and synchronous flush. Carries a control vector,
// NUM_DATA data words and a destination register index.
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   in_valid/in_ready           upstream handshake
//   in_ctrl/in_data/in_rd       upstream payload (word k at [k*DATA_W +: DATA_W])
//   flush                       synchronous kill of held and incoming entries
//   out_valid/out_ready         downstream handshake
//   out_ctrl/out_data/out_rd    held payload; out_ctrl is 0 while out_valid=0
// Build option PIPE_STAGE_SKID_EN: adds a skid entry so in_ready is a pure
// register output (no combinational path from out_ready). Without it the
// stage holds a single entry and in_ready = out_ready || !out_valid.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_DATA = NUM_DATA_DEF,
  parameter int unsigned RD_W     = RD_W_DEF,
  parameter int unsigned CTRL_W   = CTRL_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]            out_rd
);

  pipe_state_t state;
  pipe_state_t state_nxt;

  logic xfer_in;
  logic xfer_out;

  logic                       main_load;
  logic                       main_clear;
  logic                       main_valid;
  logic [CTRL_W-1:0]          main_d_ctrl;
  logic [NUM_DATA*DATA_W-1:0] main_d_data;
  logic [RD_W-1:0]            main_d_rd;

`ifdef PIPE_STAGE_SKID_EN
  logic                       main_sel_skid;
  logic                       skid_load;
  logic                       skid_clear;
  logic                       skid_valid;
  logic [CTRL_W-1:0]          skid_ctrl;
  logic [NUM_DATA*DATA_W-1:0] skid_data;
  logic [RD_W-1:0]            skid_rd;

  // Ready only depends on skid occupancy, which is a flop
  assign in_ready = !skid_valid;

  // Main refills from skid when draining TWO, otherwise from the input
  assign main_d_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_sel_skid ? skid_data : in_data;
  assign main_d_rd   = main_sel_skid ? skid_rd   : in_rd;
`else
  // Single entry: accept when empty or when the held entry leaves this cycle
  assign in_ready = out_ready || !main_valid;

  assign main_d_ctrl = in_ctrl;
  assign main_d_data = in_data;
  assign main_d_rd   = in_rd;
`endif

  assign out_valid = main_valid;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = main_valid && out_ready;

  // Next occupancy and entry load/clear strobes
  always_comb begin
    state_nxt  = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
`endif
    if (flush) begin
      state_nxt  = EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            main_load = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_out) begin
            main_clear = 1'b1;
            state_nxt  = EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (xfer_in) begin
            skid_load = 1'b1;
            state_nxt = TWO;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          if (xfer_out) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
            state_nxt     = ONE;
          end
        end
`endif
        default: begin
          state_nxt  = EMPTY;
          main_clear = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main entry drives the stage outputs
  pipe_entry_reg #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .RD_W     (RD_W),
    .CTRL_W   (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .d_rd    (main_d_rd),
    .q_valid (main_valid),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data),
    .q_rd    (out_rd)
  );

`ifdef PIPE_STAGE_SKID_EN
  // Skid entry absorbs the one transfer accepted while downstream stalls
  pipe_entry_reg #(
    .DATA_W   (DATA_W),
    .NUM_DATA (NUM_DATA),
    .RD_W     (RD_W),
    .CTRL_W   (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .d_rd    (in_rd),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data),
    .q_rd    (skid_rd)
  );
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. A queue-based
// FIFO model (capacity 2 with the skid entry, 1 without) predicts outputs.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned ND = 2;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 2;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW-1:0]   in_ctrl = '0;
  logic [ND*DW-1:0] in_data = '0;
  logic [RW-1:0]   in_rd = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_ctrl;
  logic [ND*DW-1:0] out_data;
  logic [RW-1:0]   out_rd;

  typedef struct packed {
    logic [CW-1:0]    ctrl;
    logic [ND*DW-1:0] data;
    logic [RW-1:0]    rd;
  } ent_t;

  ent_t mq[$];
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .NUM_DATA (ND),
    .RD_W     (RW),
    .CTRL_W   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rd    (out_rd)
  );

  // Model's view of whether the stage can accept right now
  function automatic logic m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  function automatic ent_t mk(int k);
    ent_t e;
    e.ctrl = CW'(k);
    e.data = {32'(k * 3 + 1), 32'(k)};
    e.rd   = RW'(k);
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.ctrl = CW'($urandom);
    e.data = {$urandom, $urandom};
    e.rd   = RW'($urandom);
    return e;
  endfunction

  task automatic put(input logic v, input ent_t e);
    in_valid = v;
    in_ctrl  = e.ctrl;
    in_data  = e.data;
    in_rd    = e.rd;
  endtask

  // Advance one clock and update the FIFO model with what crossed the edge
  task automatic tick();
    logic rdy;
    rdy = m_ready();
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) mq.push_back(ent_t'{ctrl: in_ctrl, data: in_data, rd: in_rd});
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; put(1'b1, rnd_ent());
    repeat (2) tick();
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", out_ctrl); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
    n_tests++; if (out_rd !== '0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", out_rd); end
    reset = 1'b0; put(1'b1, mk(5));
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_rd !== RW'(5) || out_data !== mk(5).data || out_ctrl !== mk(5).ctrl) begin
      n_fail++; $display("FAIL reset_first v=%b rd=%0d data=%h exp v=1 rd=5 data=%h", out_valid, out_rd, out_data, mk(5).data);
    end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) put(1'b1, mk(i)); else in_valid = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready cyc %0d got %b exp 1", i, in_ready); end
      n_tests++; if (out_valid !== (i > 0)) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b exp %b", i, out_valid, i > 0); end
      if (i > 0) begin
        n_tests++; if (out_rd !== RW'(i - 1) || out_data !== mk(i - 1).data) begin
          n_fail++; $display("FAIL stream_order cyc %0d rd=%0d exp %0d", i, out_rd, i - 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int acc;
    logic exp_rdy;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      put(1'b1, mk(10 + acc));
      #1;
      exp_rdy = (acc < CAP);
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_ready cyc %0d got %b exp %b", c, in_ready, exp_rdy); end
      n_tests++; if (out_valid !== (c > 0)) begin n_fail++; $display("FAIL stall_valid cyc %0d got %b exp %b", c, out_valid, c > 0); end
      if (exp_rdy) acc++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j <= CAP; j++) begin
      #1;
      n_tests++; if (out_valid !== (j < CAP)) begin n_fail++; $display("FAIL stall_drain_valid %0d got %b exp %b", j, out_valid, j < CAP); end
      if (j < CAP) begin
        n_tests++; if (out_rd !== RW'(10 + j)) begin n_fail++; $display("FAIL stall_drain_rd %0d got %0d exp %0d", j, out_rd, 10 + j); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin put(1'b1, mk(60 + k)); tick(); end
    reset = 1'b1; put(1'b1, mk(70));
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_rd !== '0) begin
      n_fail++; $display("FAIL rst_stall v=%b ctrl=%h rd=%0d exp 0/0/0", out_valid, out_ctrl, out_rd);
    end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_flush();
    ent_t e;
    out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) begin
      e = mk(20 + k); e.ctrl = 2'b11; put(1'b1, e); tick();
    end
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_ctrl !== 2'b11 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_full v=%b ctrl=%b rdy=%b exp 1/11/0", out_valid, out_ctrl, in_ready);
    end
    flush = 1'b1; e = mk(31); e.ctrl = 2'b11; put(1'b1, e);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full_after v=%b ctrl=%b rdy=%b exp 0/00/1", out_valid, out_ctrl, in_ready);
    end
    // Flush while an input would otherwise be accepted
    out_ready = 1'b1;
    e = mk(21); e.ctrl = 2'b11; put(1'b1, e); tick();
    flush = 1'b1; e = mk(31); e.ctrl = 2'b11; put(1'b1, e);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_open_ready got %b exp 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00) begin
        n_fail++; $display("FAIL flush_discard %0d v=%b ctrl=%b rd=%0d exp v=0 ctrl=00", j, out_valid, out_ctrl, out_rd);
      end
      tick();
    end
  endtask

  task automatic test_simul();
    ent_t prev, e;
    out_ready = 1'b1;
    prev = mk(40); put(1'b1, prev); tick();
    for (int i = 1; i <= 10; i++) begin
      e = rnd_ent(); put(1'b1, e);
      #1;
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL simul_hs %0d v=%b rdy=%b exp 1/1", i, out_valid, in_ready);
      end
      n_tests++; if (out_rd !== prev.rd || out_data !== prev.data || out_ctrl !== prev.ctrl) begin
        n_fail++; $display("FAIL simul_data %0d rd=%0d data=%h exp rd=%0d data=%h", i, out_rd, out_data, prev.rd, prev.data);
      end
      prev = e;
      tick();
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_ready_path();
    logic exp_stall;
`ifdef PIPE_STAGE_SKID_EN
    exp_stall = 1'b1;
`else
    exp_stall = 1'b0;
`endif
    out_ready = 1'b0; put(1'b1, mk(50)); tick();
    in_valid = 1'b0;
    #1;
    n_tests++; if (in_ready !== exp_stall) begin n_fail++; $display("FAIL ready_stalled got %b exp %b", in_ready, exp_stall); end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_released got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_random();
    logic  exp_v;
    logic [CW-1:0] exp_c;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      put(1'($urandom), rnd_ent());
      #1;
      exp_v = (mq.size() > 0);
      exp_c = exp_v ? mq[0].ctrl : '0;
      n_tests++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, out_valid, exp_v); end
      n_tests++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b exp %b", i, in_ready, m_ready()); end
      n_tests++; if (out_ctrl !== exp_c) begin n_fail++; $display("FAIL rand_ctrl cyc %0d got %b exp %b", i, out_ctrl, exp_c); end
      if (exp_v) begin
        n_tests++; if (out_data !== mq[0].data || out_rd !== mq[0].rd) begin
          n_fail++; $display("FAIL rand_payload cyc %0d rd=%0d data=%h exp rd=%0d data=%h", i, out_rd, out_data, mq[0].rd, mq[0].data);
        end
      end
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_reset_mid_stall();
    test_flush();
    test_simul();
    test_ready_path();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
